// File: rtl/rtc_bus_responder_if.sv
// RTC multiplexed port: active-low strobes plus responder status.
// The 8-bit Bus_Dato_Dir data lines are a plain inout port on the responder.
`timescale 1ns/1ps
interface rtc_bus_responder_if;
    logic CS;
    logic AD;
    logic WR;
    logic RD;
    logic drive_en;
    logic timer_done;

    modport master (
        output CS, AD, WR, RD,
        input  drive_en, timer_done
    );

    modport slave (
        input  CS, AD, WR, RD,
        output drive_en, timer_done
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// RTC chip emulation: address/data port responder, BCD register file,
// running clock (ss:mm:hh) and down-counting timer with sticky done flag.
`timescale 1ns/1ps
module rtc_bus_responder #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic                 CLK,
    input  logic                 Reset,
    rtc_bus_responder_if.slave   bus,
    inout  wire  [7:0]           Bus_Dato_Dir
);
    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA, S_RDATA} state_e;

    // BCD increment; anything at or above max (incl. invalid BCD) wraps to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max)             return 8'h00;
        else if (v[3:0] >= 4'd9)  return {v[7:4] + 4'd1, 4'd0};
        else                      return v + 8'd1;
    endfunction

    // BCD decrement of a nonzero value
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        else                return v - 8'd1;
    endfunction

    state_e            state_q, state_d;
    logic              cs_q, ad_q, wr_q, rd_q;
    logic [7:0]        bus_q, bus_prev_q;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        out_q, out_d;
    logic              drive_en_q, drive_en_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_c;
    logic              wr_fire_c;
    logic [7:0]        rd_data_c;
    logic [7:0]        seg_q, seg_d, min_q, min_d, hora_q, hora_d;
    logic [7:0]        dia_q, dia_d, mes_q, mes_d, ano_q, ano_d;
    logic [7:0]        seg_t_q, seg_t_d, min_t_q, min_t_d, hora_t_q, hora_t_d;
    logic              run_clk_q, run_clk_d, run_tmr_q, run_tmr_d;
    logic              timer_done_q, timer_done_d;
    logic              tmr_set_c, tmr_clr_c;

    assign Bus_Dato_Dir   = drive_en_q ? out_q : 8'hzz;
    assign bus.drive_en   = drive_en_q;
    assign bus.timer_done = timer_done_q;

    // Free-running 1 s tick, one-cycle pulse at wrap
    assign tick_c     = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    assign tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);

    // Register read mux; ctrl bit2 is write-only
    always_comb begin
        rd_data_c = 8'h00;
        case (addr_q)
            8'h02:   rd_data_c = {6'b0, run_tmr_q, run_clk_q};
            8'h21:   rd_data_c = seg_q;
            8'h22:   rd_data_c = min_q;
            8'h23:   rd_data_c = hora_q;
            8'h24:   rd_data_c = dia_q;
            8'h25:   rd_data_c = mes_q;
            8'h26:   rd_data_c = ano_q;
            8'h41:   rd_data_c = seg_t_q;
            8'h42:   rd_data_c = min_t_q;
            8'h43:   rd_data_c = hora_t_q;
            default: rd_data_c = 8'h00;
        endcase
    end

    // Bus transfer FSM: next state, address latch, read snapshot and drive enable
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        out_d      = out_q;
        drive_en_d = drive_en_q;
        wr_fire_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                drive_en_d = 1'b0;
                if (!cs_q) begin
                    if (!ad_q && !wr_q && rd_q) begin
                        state_d = S_ADDR;
                    end else if (ad_q && !wr_q && rd_q) begin
                        state_d = S_WDATA;
                    end else if (ad_q && !rd_q && wr_q) begin
                        state_d    = S_RDATA;
                        out_d      = rd_data_c;
                        drive_en_d = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (cs_q) begin
                    state_d = S_IDLE;
                end else if (wr_q) begin
                    addr_d  = bus_prev_q;
                    state_d = S_IDLE;
                end
            end
            S_WDATA: begin
                if (cs_q) begin
                    state_d = S_IDLE;
                end else if (wr_q) begin
                    wr_fire_c = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RDATA: begin
                if (rd_q || cs_q) begin
                    drive_en_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Clock/timer advance on tick, then host write overrides its own register
    always_comb begin
        seg_d     = seg_q;    min_d   = min_q;    hora_d   = hora_q;
        dia_d     = dia_q;    mes_d   = mes_q;    ano_d    = ano_q;
        seg_t_d   = seg_t_q;  min_t_d = min_t_q;  hora_t_d = hora_t_q;
        run_clk_d = run_clk_q;
        run_tmr_d = run_tmr_q;
        tmr_set_c = 1'b0;
        tmr_clr_c = 1'b0;

        if (tick_c && run_clk_q) begin
            seg_d = bcd_inc(seg_q, 8'h59);
            if (seg_q >= 8'h59) begin
                min_d = bcd_inc(min_q, 8'h59);
                if (min_q >= 8'h59) hora_d = bcd_inc(hora_q, 8'h23);
            end
        end

        if (tick_c && run_tmr_q && (seg_t_q != 8'h00 || min_t_q != 8'h00 || hora_t_q != 8'h00)) begin
            if (seg_t_q != 8'h00) begin
                seg_t_d = bcd_dec(seg_t_q);
            end else begin
                seg_t_d = 8'h59;
                if (min_t_q != 8'h00) begin
                    min_t_d = bcd_dec(min_t_q);
                end else begin
                    min_t_d  = 8'h59;
                    hora_t_d = bcd_dec(hora_t_q);
                end
            end
            tmr_set_c = (seg_t_d == 8'h00) && (min_t_d == 8'h00) && (hora_t_d == 8'h00);
        end

        if (wr_fire_c) begin
            case (addr_q)
                8'h02: begin
                    run_clk_d = bus_prev_q[0];
                    run_tmr_d = bus_prev_q[1];
                    tmr_clr_c = bus_prev_q[2];
                end
                8'h21:   seg_d    = bus_prev_q;
                8'h22:   min_d    = bus_prev_q;
                8'h23:   hora_d   = bus_prev_q;
                8'h24:   dia_d    = bus_prev_q;
                8'h25:   mes_d    = bus_prev_q;
                8'h26:   ano_d    = bus_prev_q;
                8'h41:   seg_t_d  = bus_prev_q;
                8'h42:   min_t_d  = bus_prev_q;
                8'h43:   hora_t_d = bus_prev_q;
                default: ;
            endcase
        end

        timer_done_d = tmr_set_c | (timer_done_q & ~tmr_clr_c);
    end

    // State register; bus_prev_q holds the bus as sampled while the strobe was still low
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cs_q         <= 1'b1;
            ad_q         <= 1'b0;
            wr_q         <= 1'b1;
            rd_q         <= 1'b1;
            bus_q        <= 8'h00;
            bus_prev_q   <= 8'h00;
            addr_q       <= 8'h00;
            out_q        <= 8'h00;
            drive_en_q   <= 1'b0;
            tick_cnt_q   <= '0;
            seg_q        <= 8'h00;
            min_q        <= 8'h00;
            hora_q       <= 8'h00;
            dia_q        <= 8'h00;
            mes_q        <= 8'h00;
            ano_q        <= 8'h00;
            seg_t_q      <= 8'h00;
            min_t_q      <= 8'h00;
            hora_t_q     <= 8'h00;
            run_clk_q    <= 1'b0;
            run_tmr_q    <= 1'b0;
            timer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cs_q         <= bus.CS;
            ad_q         <= bus.AD;
            wr_q         <= bus.WR;
            rd_q         <= bus.RD;
            bus_q        <= Bus_Dato_Dir;
            bus_prev_q   <= bus_q;
            addr_q       <= addr_d;
            out_q        <= out_d;
            drive_en_q   <= drive_en_d;
            tick_cnt_q   <= tick_cnt_d;
            seg_q        <= seg_d;
            min_q        <= min_d;
            hora_q       <= hora_d;
            dia_q        <= dia_d;
            mes_q        <= mes_d;
            ano_q        <= ano_d;
            seg_t_q      <= seg_t_d;
            min_t_q      <= min_t_d;
            hora_t_q     <= hora_t_d;
            run_clk_q    <= run_clk_d;
            run_tmr_q    <= run_tmr_d;
            timer_done_q <= timer_done_d;
        end
    end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a read-data scoreboard queue.
`timescale 1ns/1ps
module tb_rtc_bus_responder;
    localparam int unsigned TICKS = 8;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       host_oe;
    logic [7:0] host_d;
    wire  [7:0] bus_w;
    int         checks = 0;
    int         failures = 0;
    int         edges = 0;
    logic [7:0] exp_q[$];

    rtc_bus_responder_if bus_if();

    assign bus_w = host_oe ? host_d : 8'hzz;

    rtc_bus_responder #(.TICK_CYCLES(TICKS)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .bus          (bus_if.slave),
        .Bus_Dato_Dir (bus_w)
    );

    always #5 CLK = ~CLK;

    // Clock edges since reset release; every TICKS-th edge carries a tick
    always @(posedge CLK or posedge Reset) begin
        if (Reset) edges <= 0;
        else       edges <= edges + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic phase(input logic ad, input logic [7:0] d);
        @(negedge CLK);
        bus_if.CS = 1'b0; bus_if.AD = ad; bus_if.WR = 1'b0; bus_if.RD = 1'b1;
        host_d = d; host_oe = 1'b1;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        bus_if.WR = 1'b1; host_oe = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        phase(1'b0, a);
        phase(1'b1, d);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        int waited;
        logic [7:0] want;
        phase(1'b0, a);
        exp_q.push_back(exp);
        @(negedge CLK);
        bus_if.CS = 1'b0; bus_if.AD = 1'b1; bus_if.RD = 1'b0;
        @(posedge CLK); #1;
        check({tag, "_lat"}, 8'(bus_if.drive_en), 8'h00);
        waited = 0;
        while (!bus_if.drive_en && waited < 8) begin
            @(posedge CLK); #1;
            waited++;
        end
        check({tag, "_wait"}, 8'(waited), 8'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'(exp_q.size()), 8'd1);
        end else begin
            want = exp_q.pop_front();
            check(tag, bus_w, want);
        end
        @(negedge CLK);
        bus_if.RD = 1'b1;
        @(posedge CLK); #1;
        check({tag, "_hold"}, 8'(bus_if.drive_en), 8'h01);
        @(posedge CLK); #1;
        check({tag, "_rel"}, 8'(bus_if.drive_en), 8'h00);
    endtask

    task automatic wait_ticks(input int n);
        int seen;
        int budget;
        seen = 0;
        budget = 0;
        while (seen < n && budget < 64) begin
            @(posedge CLK); #1;
            budget++;
            if (edges % TICKS == 0) seen++;
        end
        if (seen < n) check("tick_timeout", 8'(seen), 8'(n));
    endtask

    initial begin
        Reset = 1'b1;
        bus_if.CS = 1'b1; bus_if.AD = 1'b0; bus_if.WR = 1'b1; bus_if.RD = 1'b1;
        host_oe = 1'b0; host_d = 8'h00;
        #22;
        check("rst_drive_en", 8'(bus_if.drive_en), 8'h00);
        @(negedge CLK);
        Reset = 1'b0;

        // 1: reset state
        check("rst_done", 8'(bus_if.timer_done), 8'h00);
        do_read(8'h21, 8'h00, "rst_seg");

        // 2: write then read back, then check the bus is released
        write_reg(8'h21, 8'h45);
        do_read(8'h21, 8'h45, "wr_seg");
        @(negedge CLK);
        host_d = 8'hA5; host_oe = 1'b1;
        @(posedge CLK); #1;
        check("bus_free", bus_w, 8'hA5);
        host_oe = 1'b0;
        write_reg(8'h30, 8'hAB);
        do_read(8'h30, 8'h00, "unmapped");

        // 3: clock digit carry, then full rollover 23:59:59 -> 00:00:00
        write_reg(8'h21, 8'h09);
        write_reg(8'h02, 8'h01);
        wait_ticks(1);
        phase(1'b1, 8'h00);
        do_read(8'h21, 8'h10, "clk_digit");
        write_reg(8'h21, 8'h59);
        write_reg(8'h22, 8'h59);
        write_reg(8'h23, 8'h23);
        write_reg(8'h24, 8'h15);
        write_reg(8'h02, 8'h01);
        wait_ticks(1);
        phase(1'b1, 8'h00);
        do_read(8'h21, 8'h00, "roll_seg");
        do_read(8'h22, 8'h00, "roll_min");
        do_read(8'h23, 8'h00, "roll_hora");
        do_read(8'h24, 8'h15, "roll_dia");

        // 4: timer 00:00:02 counts down, sets done, holds, clears on bit2
        write_reg(8'h41, 8'h02);
        write_reg(8'h42, 8'h00);
        write_reg(8'h43, 8'h00);
        write_reg(8'h02, 8'h02);
        wait_ticks(1);
        check("tmr_done_t1", 8'(bus_if.timer_done), 8'h00);
        wait_ticks(1);
        check("tmr_done_t2", 8'(bus_if.timer_done), 8'h01);
        wait_ticks(1);
        check("tmr_done_hold", 8'(bus_if.timer_done), 8'h01);
        phase(1'b1, 8'h04);
        check("tmr_done_clr", 8'(bus_if.timer_done), 8'h00);
        do_read(8'h41, 8'h00, "tmr_seg");
        do_read(8'h42, 8'h00, "tmr_min");
        do_read(8'h43, 8'h00, "tmr_hora");
        do_read(8'h02, 8'h00, "ctrl_rd");

        // 5: CS abort during data phase, then WR+RD low together
        write_reg(8'h21, 8'h12);
        @(negedge CLK);
        bus_if.CS = 1'b0; bus_if.AD = 1'b1; bus_if.WR = 1'b0; bus_if.RD = 1'b1;
        host_d = 8'h77; host_oe = 1'b1;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        bus_if.CS = 1'b1;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        bus_if.WR = 1'b1; host_oe = 1'b0;
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        bus_if.CS = 1'b0; bus_if.AD = 1'b1; bus_if.WR = 1'b0; bus_if.RD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("proto_err", 8'(bus_if.drive_en), 8'h00);
        end
        @(negedge CLK);
        bus_if.WR = 1'b1; bus_if.RD = 1'b1;
        @(posedge CLK); @(posedge CLK);
        do_read(8'h21, 8'h12, "abort_seg");

        // 6: reset in the middle of a read
        write_reg(8'h21, 8'h33);
        write_reg(8'h41, 8'h07);
        phase(1'b0, 8'h21);
        exp_q.push_back(8'h33);
        @(negedge CLK);
        bus_if.AD = 1'b1; bus_if.RD = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        check("mid_rd_en", 8'(bus_if.drive_en), 8'h01);
        if (exp_q.size() != 0) check("mid_rd_data", bus_w, exp_q.pop_front());
        #2;
        Reset = 1'b1;
        #1;
        check("mid_rst_en", 8'(bus_if.drive_en), 8'h00);
        @(negedge CLK);
        bus_if.RD = 1'b1; bus_if.CS = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        do_read(8'h21, 8'h00, "post_rst_seg");
        do_read(8'h41, 8'h00, "post_rst_segt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
